// File: rtl/alu_result_fifo_if.sv
// ---------------------------------------------------------------------------
// alu_result_fifo_if
// Purpose : Bundles the producer (ALU) and consumer (display/register-file)
//           handshakes of alu_result_fifo into a single interface.
// Params  : N     - ALU result width
//           DEPTH - FIFO depth (sizes the occupancy count)
// Signals : in_valid/in_result/in_flags/in_ready   - write side (valid/ready)
//           out_valid/out_result/out_flags/out_ready - read side (valid/ready)
//           count                                  - occupied entries
//           clr_sticky/sticky_cv                   - only with STICKY_FLAGS_EN
// Modports: slave  - the FIFO itself
//           master - the environment driving the FIFO (ALU + consumer)
// ---------------------------------------------------------------------------
interface alu_result_fifo_if #(
    parameter int N     = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [N-1:0]  in_result;
    logic [3:0]    in_flags;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_result;
    logic [3:0]    out_flags;
    logic          out_ready;
    logic [CW-1:0] count;
`ifdef STICKY_FLAGS_EN
    logic          clr_sticky;
    logic [1:0]    sticky_cv;
`endif

    modport slave (
        input  in_valid, in_result, in_flags, out_ready,
`ifdef STICKY_FLAGS_EN
        input  clr_sticky,
        output sticky_cv,
`endif
        output in_ready, out_valid, out_result, out_flags, count
    );

    modport master (
        output in_valid, in_result, in_flags, out_ready,
`ifdef STICKY_FLAGS_EN
        output clr_sticky,
        input  sticky_cv,
`endif
        input  in_ready, out_valid, out_result, out_flags, count
    );
endinterface

// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
// Purpose : First-word-fall-through FIFO buffering ALU results together with
//           their NZCV flags ({result, flags}, flags = [3]N [2]Z [1]C [0]V).
//           Decouples the ALU from the display/register-file consumer.
// Params  : N (result width), DEPTH (entries, power of two, >= 2)
// Ports   : clk  - single clock, rising edge
//           rst  - asynchronous reset, active-high
//           bus  - alu_result_fifo_if.slave (write/read handshakes, count)
// Options : STICKY_FLAGS_EN - adds clr_sticky/sticky_cv: accumulates the C and
//           V flags of every pushed entry until cleared.
// ---------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_result_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    logic [N+3:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    state_t        r_state;
    state_t        w_state_next;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;

    assign w_push = bus.in_valid & w_in_ready;
    assign w_pop  = w_out_valid & bus.out_ready;

    // Storage carries no reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_result, bus.in_flags};
        end
    end

    // Pointers wrap modulo DEPTH through natural AW-bit overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic; the state mirrors the occupancy count.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_state_next = PARTIAL;
                end
            end
            PARTIAL: begin
                if (w_push && !w_pop && (r_count == CW'(DEPTH - 1))) begin
                    w_state_next = FULL;
                end else if (w_pop && !w_push && (r_count == CW'(1))) begin
                    w_state_next = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_state_next = PARTIAL;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    // FSM: outputs. in_ready ignores out_ready: a full FIFO never passes
    // a new entry through, even while the head is being consumed.
    always_comb begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        case (r_state)
            EMPTY: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b0;
            end
            PARTIAL: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b1;
            end
            FULL: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b1;
            end
            default: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.count     = r_count;

    // Fall-through head; forced to zero while empty so stale storage
    // never leaks onto the output.
    assign {bus.out_result, bus.out_flags} = w_out_valid ? r_mem[r_rd_ptr] : '0;

`ifdef STICKY_FLAGS_EN
    logic [1:0] r_sticky_cv;

    // Clear takes priority over accumulation from a same-cycle push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_cv <= 2'b00;
        end else if (bus.clr_sticky) begin
            r_sticky_cv <= 2'b00;
        end else if (w_push) begin
            r_sticky_cv <= r_sticky_cv | bus.in_flags[1:0];
        end
    end

    assign bus.sticky_cv = r_sticky_cv;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_alu_result_fifo
// Directed test of alu_result_fifo: a queue model holds the expected
// contents; every cycle checks handshakes, head data and count against it.
// ---------------------------------------------------------------------------
module tb_alu_result_fifo;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_result_fifo_if #(.N(N), .DEPTH(DEPTH)) bus ();

    alu_result_fifo #(.N(N), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [N-1:0] r;
        logic [3:0]   f;
    } ent_t;

    ent_t       q[$];
    logic [1:0] sticky_m = 2'b00;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         step_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock of stimulus: drive, check pre-edge outputs against the
    // model, clock, update the model, check post-edge count.
    task automatic cycle(input bit pv, input logic [N-1:0] r, input logic [3:0] f,
                         input bit pr, input bit clr = 1'b0);
        bit   do_push;
        bit   do_pop;
        ent_t e;
        bus.in_valid  = pv;
        bus.in_result = r;
        bus.in_flags  = f;
        bus.out_ready = pr;
`ifdef STICKY_FLAGS_EN
        bus.clr_sticky = clr;
`endif
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(q.size() != DEPTH));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("head_result", 32'(bus.out_result), 32'(q[0].r));
            check("head_flags", 32'(bus.out_flags), 32'(q[0].f));
        end else begin
            check("empty_result", 32'(bus.out_result), 32'd0);
            check("empty_flags", 32'(bus.out_flags), 32'd0);
        end
        do_push = pv && (q.size() < DEPTH);
        do_pop  = pr && (q.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop) begin
            void'(q.pop_front());
        end
        if (do_push) begin
            e.r = r;
            e.f = f;
            q.push_back(e);
        end
        if (clr) begin
            sticky_m = 2'b00;
        end else if (do_push) begin
            sticky_m = sticky_m | f[1:0];
        end
        check("count", 32'(bus.count), 32'(q.size()));
`ifdef STICKY_FLAGS_EN
        check("sticky_cv", 32'(bus.sticky_cv), 32'(sticky_m));
`endif
        step_cnt++;
        $display("step %0d: valid=%0b data=%h/%b ready=%0b clr=%0b push=%0b pop=%0b count=%0d",
                 step_cnt, pv, r, f, pr, clr, do_push, do_pop, bus.count);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_count"}, 32'(bus.count), 32'd0);
        check({tag, "_out_result"}, 32'(bus.out_result), 32'd0);
        check({tag, "_out_flags"}, 32'(bus.out_flags), 32'd0);
`ifdef STICKY_FLAGS_EN
        check({tag, "_sticky_cv"}, 32'(bus.sticky_cv), 32'd0);
`endif
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic mid_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        sticky_m = 2'b00;
        $display("mid-cycle reset applied");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_flags  = '0;
        bus.out_ready = 1'b0;
`ifdef STICKY_FLAGS_EN
        bus.clr_sticky = 1'b0;
`endif
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: fill partially, then reset mid-cycle
        cycle(1, 4'h3, 4'b0011, 0);
        cycle(1, 4'h5, 4'b0101, 0);
        mid_reset();

        // T2: two pushes, then pop them
        cycle(1, 4'h8, 4'b1000, 0);
        cycle(1, 4'h0, 4'b0100, 0);
        cycle(0, 4'hF, 4'b1111, 1);
        cycle(0, 4'hF, 4'b1111, 1);
        // empty: out_ready ignored
        cycle(0, 4'h0, 4'b0000, 1);

        // T3: five pushes into a four-deep FIFO; fifth is dropped
        for (int i = 1; i <= 5; i++) begin
            cycle(1, 4'(i), 4'(i * 3), 0);
        end
        // full: pop occurs, simultaneous push is refused
        cycle(1, 4'hE, 4'b1110, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 4'h0, 4'b0000, 1);
        end

        // T4: count=2 then simultaneous push and pop
        cycle(1, 4'hA, 4'b1010, 0);
        cycle(1, 4'hB, 4'b1001, 0);
        cycle(1, 4'hC, 4'b0110, 1);
        cycle(0, 4'h0, 4'b0000, 1);
        cycle(0, 4'h0, 4'b0000, 1);

        // T5: ten push/pop pairs wrap the pointers
        for (int i = 0; i < 10; i++) begin
            cycle(1, 4'(i + 6), 4'(15 - i), 0);
            cycle(0, 4'h0, 4'b0000, 1);
        end

`ifdef STICKY_FLAGS_EN
        // T6: sticky C/V accumulation, clear wins over push
        cycle(1, 4'h1, 4'b0010, 0);
        cycle(1, 4'h2, 4'b0001, 0);
        cycle(1, 4'h3, 4'b0010, 0, 1'b1);
        cycle(0, 4'h0, 4'b0000, 1);
        cycle(0, 4'h0, 4'b0000, 1);
        cycle(0, 4'h0, 4'b0000, 1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
